// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants for the RAM-backed stream FIFO controller.
package ram_fifo_ctrl_pkg;

    localparam int unsigned DefAw    = 9;
    localparam int unsigned DefDw    = 64;
    // Output buffer entries that absorb the RAM read latency.
    localparam int unsigned BufDepth = 2;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop stream handshake between a producer/consumer and the FIFO controller.
interface ram_fifo_ctrl_if #(
    parameter int unsigned DW = 64
) ();

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    // Producer/consumer side.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // FIFO side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/ram_fifo_ctrl_fifo_out_buf.sv
// Two-entry registered output buffer; entry 0 is always the head.
module fifo_out_buf #(
    parameter int unsigned DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    cnt
);

    logic [DW-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          pop;

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = e0_q;
    assign cnt       = cnt_q;
    assign pop       = out_valid & out_ready;

    // Next-state for entries and count; the caller never writes into a full buffer.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 2'd0;
        end else begin
            case ({in_valid, pop})
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        e0_d = e1_q;
                        e1_d = in_data;
                    end else begin
                        e0_d = in_data;
                    end
                end
                2'b01: begin
                    e0_d  = e1_q;
                    cnt_d = cnt_q - 2'd1;
                end
                2'b10: begin
                    if (cnt_q == 2'd0) e0_d = in_data;
                    else               e1_d = in_data;
                    cnt_d = cnt_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= 2'd0;
        else      cnt_q <= cnt_d;
    end

    // Data registers carry no reset.
    always_ff @(posedge clk) begin
        e0_q <= e0_d;
        e1_q <= e1_d;
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Access-side controller turning a 1-cycle-latency dual-port RAM into a stream FIFO.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned AW    = DefAw,
    parameter int unsigned DW    = DefDw,
    parameter int unsigned DEPTH = (1 << AW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    ram_fifo_ctrl_if.slave bus,
    output logic [AW+1:0] level,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wr,
    output logic          ram_we,
    output logic [AW-1:0] ram_raddr,
    output logic          ram_re,
    input  logic [DW-1:0] ram_rd
);

    localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

    logic [AW:0]   wptr_q, rptr_q, ram_cnt_q, ram_cnt_d;
    logic          inflight_q;
    logic [AW+1:0] level_q, level_d;
    logic [1:0]    buf_cnt, buf_cnt_d;
    logic [2:0]    occ;
    logic          in_ready_w, push, pop, re;

    // Ready is held low while reset is asserted.
    assign in_ready_w   = rst & (ram_cnt_q != FullCnt);
    assign bus.in_ready = in_ready_w;
    assign push         = bus.in_valid & in_ready_w & ~flush;
    assign pop          = bus.out_valid & bus.out_ready;

    // Words that will sit in the buffer after this cycle if no read is issued.
    assign occ = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    // ram_cnt excludes this cycle's write, so a read never hits the write address.
    assign re  = ~flush & (ram_cnt_q != '0) & (occ < 3'(BufDepth));

    assign ram_we    = push;
    assign ram_waddr = wptr_q[AW-1:0];
    assign ram_wr    = bus.in_data;
    assign ram_re    = re;
    assign ram_raddr = rptr_q[AW-1:0];
    assign level     = level_q;

    // Next RAM count, buffer count and total level.
    always_comb begin
        ram_cnt_d = ram_cnt_q + (AW+1)'(push) - (AW+1)'(re);
        buf_cnt_d = buf_cnt + {1'b0, inflight_q} - {1'b0, pop};
        if (flush) begin
            ram_cnt_d = '0;
            buf_cnt_d = 2'd0;
        end
        level_d = {1'b0, ram_cnt_d} + (AW+2)'(re) + (AW+2)'(buf_cnt_d);
    end

    // Pointer, count and in-flight state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            level_q    <= '0;
        end else if (flush) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            level_q    <= '0;
        end else begin
            wptr_q     <= wptr_q + (AW+1)'(push);
            rptr_q     <= rptr_q + (AW+1)'(re);
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= re;
            level_q    <= level_d;
        end
    end

    // Read data returns one cycle after issue and lands in the buffer tail.
    fifo_out_buf #(
        .DW (DW)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .in_valid  (inflight_q),
        .in_data   (ram_rd),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data),
        .cnt       (buf_cnt)
    );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench: behavioural 512x64 RAM plus a scoreboard queue of pushed words.
module tb_ram_fifo_ctrl;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic [AW+1:0] level;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [DW-1:0] ram_wr, ram_rd;
    logic          ram_we, ram_re;

    logic [DW-1:0] mem [512];
    logic [DW-1:0] exp_q [$];
    int            n_vec = 0;
    int            n_err = 0;
    int            n_pop = 0;
    int            max_level = 0;

    ram_fifo_ctrl_if #(.DW(DW)) bus ();

    ram_fifo_ctrl #(
        .AW (AW),
        .DW (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .level     (level),
        .ram_waddr (ram_waddr),
        .ram_wr    (ram_wr),
        .ram_we    (ram_we),
        .ram_raddr (ram_raddr),
        .ram_re    (ram_re),
        .ram_rd    (ram_rd)
    );

    always #5 clk = ~clk;

    // RAM model: registered read, write-first on collision, never reset.
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wr;
        if (ram_re) ram_rd <= (ram_we && ram_waddr == ram_raddr) ? ram_wr : mem[ram_raddr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 30) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: sampled mid-cycle, level checked against words accepted minus words popped.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
        end else begin
            chk("level", 64'(level), 64'(exp_q.size()));
            if (int'(level) > max_level) max_level = int'(level);
            if (flush) begin
                exp_q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    n_pop++;
                    if (exp_q.size() == 0) chk("underflow", 64'(bus.out_valid), 64'd0);
                    else                   chk("out_data", bus.out_data, exp_q.pop_front());
                end
                if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input logic [63:0] base, input string tag);
        int  k = 0;
        int  cyc = 0;
        logic acc;
        bus.in_valid = 1'b1;
        while (k < n && cyc < 5000) begin
            bus.in_data = base + 64'(k);
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            if (acc) k++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk({tag, "_push_timeout"}, 64'(cyc >= 5000), 64'd0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        bus.out_ready = 1'b0;
        chk({tag, "_drain_timeout"}, 64'(n >= 3000), 64'd0);
        tick();
        tick();
        chk({tag, "_empty_valid"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int pushed;
        int cyc;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_level", 64'(level), 64'd0);
            chk("rst_we", 64'(ram_we), 64'd0);
            chk("rst_re", 64'(ram_re), 64'd0);
            chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        end
        rst = 1'b1;
        #1;
        chk("rel_in_ready", 64'(bus.in_ready), 64'd1);
        tick();

        // Single push: visible two edges after acceptance.
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hDEAD_BEEF_0000_0001;
        tick();
        bus.in_valid = 1'b0;
        chk("single_v0", 64'(bus.out_valid), 64'd0);
        tick();
        chk("single_v1", 64'(bus.out_valid), 64'd0);
        tick();
        chk("single_v2", 64'(bus.out_valid), 64'd1);
        chk("single_data", bus.out_data, 64'hDEAD_BEEF_0000_0001);
        chk("single_level", 64'(level), 64'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("single_level0", 64'(level), 64'd0);
        chk("single_valid0", 64'(bus.out_valid), 64'd0);

        // Fill to capacity with the consumer stalled.
        push_n(514, 64'd0, "fill");
        tick();
        tick();
        chk("fill_in_ready", 64'(bus.in_ready), 64'd0);
        chk("fill_level", 64'(level), 64'd514);
        chk("fill_sb", 64'(exp_q.size()), 64'd514);
        drain("fill");

        // Random 70% stream of 2000 words; wraps the pointers several times.
        pushed = 0;
        cyc    = 0;
        while ((pushed < 2000 || exp_q.size() != 0) && cyc < 20000) begin
            bus.in_valid  = (pushed < 2000) && ($urandom_range(9) < 7);
            bus.in_data   = {$urandom, $urandom};
            bus.out_ready = ($urandom_range(9) < 7);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) pushed++;
            tick();
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("stream_timeout", 64'(cyc >= 20000), 64'd0);
        chk("stream_max_level", 64'(max_level > 514), 64'd0);

        // Continuous ready: 30 words must come out back-to-back after the fill latency.
        tick();
        cnt = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.in_valid = (i < 30);
            bus.in_data  = 64'h1000 + 64'(i);
            @(negedge clk);
            if (i >= 3 && i < 33 && bus.out_valid) cnt++;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("burst_no_bubbles", 64'(cnt), 64'd30);
        chk("burst_sb_empty", 64'(exp_q.size()), 64'd0);

        // Flush with 300 held and a read in flight.
        push_n(300, 64'h5000, "flush");
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'hBAD;
        @(negedge clk);
        chk("flush_we", 64'(ram_we), 64'd0);
        chk("flush_re", 64'(ram_re), 64'd0);
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_level", 64'(level), 64'd0);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        n_pop = 0;
        push_n(1, 64'h15, "post_flush");
        drain("post_flush");
        chk("post_flush_pops", 64'(n_pop), 64'd1);

        // Asynchronous reset between clock edges while streaming.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = 64'h7700 + 64'(i);
            tick();
        end
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_level", 64'(level), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_pop = 0;
        push_n(3, 64'd1, "arst");
        drain("arst");
        chk("arst_pops", 64'(n_pop), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
